// File: rtl/aes_pipe.sv
// aes_pipe: fully unrolled AES-128/192/256 encryption pipeline with global-stall valid/ready flow.
// Define AES_PIPE_TAG_EN to build the per-block sideband tag chain; otherwise tag_o is tied to 0.
module aes_pipe #(
  parameter  int KEY_BITS = 128,
  parameter  int TAG_W    = 8,
  localparam int NR       = KEY_BITS / 32 + 6,
  localparam int CW       = $clog2(NR + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [127:0]          plaintext_i,
  input  logic [TAG_W-1:0]      tag_i,
  input  logic [NR:0][127:0]    round_key_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [127:0]          ciphertext_o,
  output logic [TAG_W-1:0]      tag_o,
  output logic [CW-1:0]         in_flight_o
);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("aes_pipe: KEY_BITS must be 128, 192 or 256");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (x & {8{b[i]}});
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  // One AES round: SubBytes, ShiftRows, MixColumns (skipped when last), AddRoundKey.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [0:15][7:0] sb;
    logic [0:15][7:0] sr;
    logic [0:15][7:0] mc;
    logic [7:0] a0, a1, a2, a3;
    sb = s;
    for (int i = 0; i < 16; i++) sb[i] = sbox(sb[i]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c + r] = sb[4*((c + r) % 4) + r];
      end
    end
    mc = sr;
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c + 1];
      a2 = sr[4*c + 2];
      a3 = sr[4*c + 3];
      mc[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return (last ? sr : mc) ^ k;
  endfunction

  logic [127:0]  state_q [1:NR];
  logic [127:0]  state_d [1:NR];
  logic [NR:1]   vld_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          stall;
  logic          accept;
  logic          xfer;

  // The whole pipe freezes together while the output block waits on the consumer.
  assign stall  = vld_q[NR] & ~ready_i;
  assign accept = valid_i & ~stall;
  assign xfer   = vld_q[NR] & ready_i;

  always_comb begin
    state_d[1] = aes_round(plaintext_i ^ round_key_i[0], round_key_i[1], 1'b0);
    for (int i = 2; i <= NR; i++) begin
      state_d[i] = aes_round(state_q[i-1], round_key_i[i], i == NR);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, xfer})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= NR; i++) state_q[i] <= 128'd0;
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (!stall) begin
        for (int i = 1; i <= NR; i++) state_q[i] <= state_d[i];
        vld_q <= {vld_q[NR-1:1], valid_i};
      end
    end
  end

`ifdef AES_PIPE_TAG_EN
  logic [TAG_W-1:0] tag_q [1:NR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= NR; i++) tag_q[i] <= '0;
    end else if (!stall) begin
      if (valid_i) tag_q[1] <= tag_i;
      for (int i = 2; i <= NR; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_o = tag_q[NR];
`else
  logic unused_tag;
  assign unused_tag = ^tag_i;
  assign tag_o      = {TAG_W{1'b0}};
`endif

  assign ready_o      = ~stall;
  assign valid_o      = vld_q[NR];
  assign ciphertext_o = state_q[NR];
  assign in_flight_o  = cnt_q;

endmodule
